// File: rtl/mem_dbus_if.sv
// mem_dbus_if: registered strobe/ack data bus between the MEM stage (master)
// and the data memory (slave). Byte enables are big-endian: sel[3] is the
// byte at addr[1:0] = 00.
interface mem_dbus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] dbus_addr_o;
  logic [DATA_W-1:0] dbus_data_o;
  logic [3:0]        dbus_sel_o;
  logic              dbus_we_o;
  logic              dbus_stb_o;
  logic [DATA_W-1:0] dbus_data_i;
  logic              dbus_ack_i;

  modport master (
    output dbus_addr_o,
    output dbus_data_o,
    output dbus_sel_o,
    output dbus_we_o,
    output dbus_stb_o,
    input  dbus_data_i,
    input  dbus_ack_i
  );

  modport slave (
    input  dbus_addr_o,
    input  dbus_data_o,
    input  dbus_sel_o,
    input  dbus_we_o,
    input  dbus_stb_o,
    output dbus_data_i,
    output dbus_ack_i
  );
endinterface

// File: rtl/mem_dbus.sv
// mem_dbus: MEM stage of the 5-stage MIPS pipeline.
// Non-memory ops pass the EX results straight through. Loads and stores run
// one registered strobe/ack bus transaction (IDLE -> BUSY -> DONE) with
// big-endian byte-lane steering and sign/zero extension, holding the pipeline
// through stallreq_o until the access completes.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses
// issue no bus cycle; loads then return 0 with the register write suppressed.
module mem_dbus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  mem_dbus_if.master  dbus,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic f_is_load(input logic [7:0] op);
    logic res;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: res = 1'b1;
      default:                                                 res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic f_is_store(input logic [7:0] op);
    logic res;
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

  // Big-endian byte enables: lane 00 is the most significant byte.
  function automatic logic [3:0] f_lane_sel(input logic [7:0] op, input logic [1:0] lane);
    logic [3:0] res;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        case (lane)
          2'b00:   res = 4'b1000;
          2'b01:   res = 4'b0100;
          2'b10:   res = 4'b0010;
          default: res = 4'b0001;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: res = lane[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             res = 4'b1111;
      default:                          res = 4'b0000;
    endcase
    return res;
  endfunction

  // Store data is replicated into every lane so the enables alone pick it.
  function automatic logic [31:0] f_store_data(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] res;
    case (op)
      EXE_SB_OP: res = {4{d[7:0]}};
      EXE_SH_OP: res = {2{d[15:0]}};
      EXE_SW_OP: res = d;
      default:   res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_load_data(input logic [7:0] op, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'b00:   b = w[31:24];
      2'b01:   b = w[23:16];
      2'b10:   b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    case (op)
      EXE_LB_OP:  res = {{24{b[7]}}, b};
      EXE_LBU_OP: res = {24'h00_0000, b};
      EXE_LH_OP:  res = {{16{h[15]}}, h};
      EXE_LHU_OP: res = {16'h0000, h};
      default:    res = w;
    endcase
    return res;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [7:0] op, input logic [1:0] lane);
    logic res;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: res = lane[0];
      EXE_LW_OP, EXE_SW_OP:             res = (lane != 2'b00);
      default:                          res = 1'b0;
    endcase
    return res;
  endfunction
`endif

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_sel;
  logic              r_we;
  logic              r_stb;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        r_op;
  logic [1:0]        r_lane;
  logic              w_is_mem;
  logic              w_is_store;
  logic              w_misalign;
  logic              w_done_load;
  logic              w_unused_stall;
`ifdef MEM_ALIGN_CHECK_EN
  logic              r_misalign;
`endif

  assign w_is_store     = f_is_store(aluop_i);
  assign w_is_mem       = f_is_load(aluop_i) | w_is_store;
  assign w_done_load    = f_is_load(r_op);
  // Only the MEM/WB hold bit matters to this stage.
  assign w_unused_stall = ^{stall[5], stall[3:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign     = f_misaligned(aluop_i, mem_addr_i[1:0]);
`else
  assign w_misalign     = 1'b0;
`endif

  assign wd_o    = wd_i;
  assign hi_o    = hi_i;
  assign lo_o    = lo_i;
  assign whilo_o = whilo_i;

  assign dbus.dbus_addr_o = r_addr;
  assign dbus.dbus_data_o = r_data;
  assign dbus.dbus_sel_o  = r_sel;
  assign dbus.dbus_we_o   = r_we;
  assign dbus.dbus_stb_o  = r_stb;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, stall request and write-back result selection.
  always_comb begin
    w_next_state = r_state;
    stallreq_o   = 1'b0;
    wdata_o      = wdata_i;
    wreg_o       = wreg_i;
    case (r_state)
      IDLE: begin
        if (w_is_mem) begin
          stallreq_o   = 1'b1;
          w_next_state = w_misalign ? DONE : BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        if (dbus.dbus_ack_i) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUSY;
        end
      end
      DONE: begin
        if (w_done_load) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (r_misalign) begin
            wdata_o = 32'h0000_0000;
            wreg_o  = 1'b0;
          end else begin
            wdata_o = f_load_data(r_op, r_lane, r_rdata);
          end
`else
          wdata_o = f_load_data(r_op, r_lane, r_rdata);
`endif
        end else begin
          wdata_o = wdata_i;
        end
        // Another stall source holding MEM/WB keeps the result here.
        if (stall[4]) begin
          w_next_state = DONE;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Bus request registers and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_sel   <= 4'b0000;
      r_we    <= 1'b0;
      r_stb   <= 1'b0;
      r_rdata <= '0;
      r_op    <= 8'h00;
      r_lane  <= 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mem) begin
            r_op   <= aluop_i;
            r_lane <= mem_addr_i[1:0];
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign <= w_misalign;
`endif
            if (w_misalign) begin
              r_stb <= 1'b0;
              r_we  <= 1'b0;
            end else begin
              r_addr <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              r_sel  <= f_lane_sel(aluop_i, mem_addr_i[1:0]);
              r_data <= f_store_data(aluop_i, reg2_i);
              r_we   <= w_is_store;
              r_stb  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dbus.dbus_ack_i) begin
            r_rdata <= dbus.dbus_data_i;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        DONE: begin
          r_stb <= 1'b0;
          r_we  <= 1'b0;
        end
        default: begin
          r_stb <= 1'b0;
          r_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus.sv
// tb_mem_dbus: table-driven bench for the MEM stage. Pass-through vectors are
// checked directly; memory vectors push their expectation onto a scoreboard
// queue when driven and pop it when the DUT presents the DONE result.
module tb_mem_dbus;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_NOP = 8'b0000_0000;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    logic [31:0] wdata;
    int          waits;
    int          hold;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] bdata;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } nm_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;

  mem_dbus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_dbus #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .dbus(bus), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   stb_txn = 0;
  logic stb_prev = 1'b0;
  vec_t sb_q[$];
  vec_t vecs[13];
  nm_t  nms[4];

  // Count strobe rising edges as seen at clock edges (one per bus transaction).
  always @(posedge clk) begin
    if (bus.dbus_stb_o && !stb_prev) stb_txn++;
    stb_prev = bus.dbus_stb_o;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    aluop_i = OP_NOP; wdata_i = 32'h0000_0000; wd_i = 5'd0; wreg_i = 1'b0;
    mem_addr_i = 32'h0000_0000; reg2_i = 32'h0000_0000; stall = 6'b000000;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                              input logic [31:0] rdata, input logic [31:0] wdata, input int waits,
                              input int hold, input logic [3:0] sel, input logic we,
                              input logic [31:0] bdata, input logic [31:0] res);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.wdata = wdata;
    v.waits = waits; v.hold = hold; v.sel = sel; v.we = we; v.bdata = bdata; v.res = res;
    return v;
  endfunction

  // One full memory transaction; leaves the DUT in IDLE with the op still driven.
  task automatic do_mem(input vec_t v);
    int   sr;
    int   txn0;
    vec_t e;
    logic [31:0] exp_addr;
    logic        is_ld;
    is_ld    = !v.we;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    txn0     = stb_txn;
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; wdata_i = v.wdata;
    wd_i = 5'd9; wreg_i = is_ld; stall = 6'b000000;
    sb_q.push_back(v);
    #1;
    sr = stallreq_o ? 1 : 0;
    check("idle_stb", {31'd0, bus.dbus_stb_o}, 32'd0);
    step();
    check("busy_stb", {31'd0, bus.dbus_stb_o}, 32'd1);
    check("bus_addr", bus.dbus_addr_o, exp_addr);
    check("bus_sel",  {28'd0, bus.dbus_sel_o}, {28'd0, v.sel});
    check("bus_we",   {31'd0, bus.dbus_we_o}, {31'd0, v.we});
    if (v.we) check("bus_data", bus.dbus_data_o, v.bdata);
    sr += stallreq_o ? 1 : 0;
    for (int w = 0; w < v.waits; w++) begin
      step();
      check("wait_stb",  {31'd0, bus.dbus_stb_o}, 32'd1);
      check("wait_addr", bus.dbus_addr_o, exp_addr);
      sr += stallreq_o ? 1 : 0;
    end
    bus.dbus_data_i = v.rdata;
    bus.dbus_ack_i  = 1'b1;
    step();
    bus.dbus_ack_i  = 1'b0;
    bus.dbus_data_i = 32'h5555_AAAA;
    if (v.hold > 0) stall = 6'b010000;
    check("done_stb",      {31'd0, bus.dbus_stb_o}, 32'd0);
    check("done_stallreq", {31'd0, stallreq_o}, 32'd0);
    check("stallreq_cycles", sr, v.waits + 2);
    check("one_txn", stb_txn - txn0, 32'd1);
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: queue empty at DONE, got %h", wdata_o);
    end else begin
      e = sb_q.pop_front();
      check("done_wdata", wdata_o, e.res);
      check("done_wd",    {27'd0, wd_o}, 32'd9);
      check("done_wreg",  {31'd0, wreg_o}, {31'd0, is_ld});
    end
    for (int h = 0; h < v.hold; h++) begin
      step();
      check("hold_wdata",    wdata_o, v.res);
      check("hold_stb",      {31'd0, bus.dbus_stb_o}, 32'd0);
      check("hold_stallreq", {31'd0, stallreq_o}, 32'd0);
    end
    if (v.hold > 0) check("hold_one_txn", stb_txn - txn0, 32'd1);
    stall = 6'b000000;
    step();
  endtask

  initial begin
    nms[0] = '{OP_ADD,        32'h1234_5678, 5'd3,  1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0};
    nms[1] = '{8'b1110_0010,  32'hA5A5_0001, 5'd17, 1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1};
    nms[2] = '{8'b1110_1010,  32'h0F0F_F0F0, 5'd31, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0};
    nms[3] = '{8'b0110_0011,  32'hDEAD_0000, 5'd1,  1'b1, 32'h3333_4444, 32'h5555_6666, 1'b1};

    vecs[0]  = mk(OP_LB,  32'h0000_1001, 32'h0, 32'hAA80_CCDD, 32'h0000_1001, 0, 0, 4'b0100, 1'b0, 32'h0, 32'hFFFF_FF80);
    vecs[1]  = mk(OP_LBU, 32'h0000_1001, 32'h0, 32'hAA80_CCDD, 32'h0000_1001, 0, 0, 4'b0100, 1'b0, 32'h0, 32'h0000_0080);
    vecs[2]  = mk(OP_SH,  32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h0BAD_0002, 3, 0, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0BAD_0002);
    vecs[3]  = mk(OP_LH,  32'h0000_1000, 32'h0, 32'h8123_4567, 32'h0000_1000, 1, 0, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8123);
    vecs[4]  = mk(OP_LHU, 32'h0000_1002, 32'h0, 32'h8123_F567, 32'h0000_1002, 0, 0, 4'b0011, 1'b0, 32'h0, 32'h0000_F567);
    vecs[5]  = mk(OP_LB,  32'h0000_1003, 32'h0, 32'h1122_3344, 32'h0000_1003, 0, 0, 4'b0001, 1'b0, 32'h0, 32'h0000_0044);
    vecs[6]  = mk(OP_LB,  32'h0000_1000, 32'h0, 32'h9122_3344, 32'h0000_1000, 0, 0, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF91);
    vecs[7]  = mk(OP_LB,  32'h0000_1002, 32'h0, 32'h1122_B344, 32'h0000_1002, 2, 0, 4'b0010, 1'b0, 32'h0, 32'hFFFF_FFB3);
    vecs[8]  = mk(OP_SB,  32'h0000_4003, 32'h1234_56A5, 32'h0, 32'h0BAD_0008, 1, 0, 4'b0001, 1'b1, 32'hA5A5_A5A5, 32'h0BAD_0008);
    vecs[9]  = mk(OP_SW,  32'h0000_4008, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_0009, 2, 0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_0009);
    vecs[10] = mk(OP_LW,  32'h0000_4004, 32'h0, 32'hCAFE_F00D, 32'h0000_4004, 0, 4, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    vecs[11] = mk(OP_LH,  32'h0000_1002, 32'h0, 32'h1234_8765, 32'h0000_1002, 0, 0, 4'b0011, 1'b0, 32'h0, 32'hFFFF_8765);
    vecs[12] = mk(OP_LBU, 32'h0000_1000, 32'h0, 32'hF122_3344, 32'h0000_1000, 0, 1, 4'b1000, 1'b0, 32'h0, 32'h0000_00F1);

    rst = 1'b1;
    drive_nop();
    hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b0;
    bus.dbus_data_i = 32'h0; bus.dbus_ack_i = 1'b0;
    step(); step();

    // Reset state.
    check("rst_stb",  {31'd0, bus.dbus_stb_o}, 32'd0);
    check("rst_we",   {31'd0, bus.dbus_we_o}, 32'd0);
    check("rst_addr", bus.dbus_addr_o, 32'd0);
    check("rst_data", bus.dbus_data_o, 32'd0);
    check("rst_sel",  {28'd0, bus.dbus_sel_o}, 32'd0);
    rst = 1'b0;
    step();
    check("rst_stallreq", {31'd0, stallreq_o}, 32'd0);

    // Non-memory pass-through, zero latency.
    for (int i = 0; i < 4; i++) begin
      aluop_i = nms[i].op; wdata_i = nms[i].wdata; wd_i = nms[i].wd; wreg_i = nms[i].wreg;
      hi_i = nms[i].hi; lo_i = nms[i].lo; whilo_i = nms[i].whilo;
      mem_addr_i = 32'h0000_1001; reg2_i = 32'h1234_5678;
      #1;
      check("nm_wdata",    wdata_o, nms[i].wdata);
      check("nm_wd",       {27'd0, wd_o}, {27'd0, nms[i].wd});
      check("nm_wreg",     {31'd0, wreg_o}, {31'd0, nms[i].wreg});
      check("nm_hi",       hi_o, nms[i].hi);
      check("nm_lo",       lo_o, nms[i].lo);
      check("nm_whilo",    {31'd0, whilo_o}, {31'd0, nms[i].whilo});
      check("nm_stallreq", {31'd0, stallreq_o}, 32'd0);
      step();
      check("nm_stb",      {31'd0, bus.dbus_stb_o}, 32'd0);
    end
    hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b0;

    // Memory ops, back to back (each new op arrives right after DONE).
    for (int i = 0; i < 13; i++) do_mem(vecs[i]);
    drive_nop();
    #1;
    check("after_mem_stallreq", {31'd0, stallreq_o}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    // Reset while BUSY: strobe drops, late ack ignored.
    aluop_i = OP_LW; mem_addr_i = 32'h0000_5000; wdata_i = 32'h0000_5000; wreg_i = 1'b1;
    step();
    check("rb_stb_up", {31'd0, bus.dbus_stb_o}, 32'd1);
    rst = 1'b1;
    drive_nop();
    wdata_i = 32'h7777_0000;
    step();
    check("rb_stb",  {31'd0, bus.dbus_stb_o}, 32'd0);
    check("rb_we",   {31'd0, bus.dbus_we_o}, 32'd0);
    check("rb_addr", bus.dbus_addr_o, 32'd0);
    rst = 1'b0;
    bus.dbus_data_i = 32'hDEAD_DEAD; bus.dbus_ack_i = 1'b1;
    step();
    bus.dbus_ack_i = 1'b0;
    check("late_ack_stb",      {31'd0, bus.dbus_stb_o}, 32'd0);
    check("late_ack_stallreq", {31'd0, stallreq_o}, 32'd0);
    check("late_ack_wdata",    wdata_o, 32'h7777_0000);
    step();
    check("late_ack_idle_stb", {31'd0, bus.dbus_stb_o}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW: no bus cycle, one-cycle stall, result suppressed.
    begin
      int txn0;
      txn0 = stb_txn;
      aluop_i = OP_LW; mem_addr_i = 32'h0000_3001; wdata_i = 32'h1111_2222; wreg_i = 1'b1; wd_i = 5'd4;
      #1;
      check("mis_idle_stallreq", {31'd0, stallreq_o}, 32'd1);
      step();
      check("mis_stb",      {31'd0, bus.dbus_stb_o}, 32'd0);
      check("mis_stallreq", {31'd0, stallreq_o}, 32'd0);
      check("mis_wdata",    wdata_o, 32'd0);
      check("mis_wreg",     {31'd0, wreg_o}, 32'd0);
      step();
      drive_nop();
      step();
      check("mis_no_txn", stb_txn - txn0, 32'd0);
    end
`else
    // Without the alignment check the low address bits are simply ignored.
    do_mem(mk(OP_LW, 32'h0000_3001, 32'h0, 32'h0123_4567, 32'h0000_3001, 0, 0, 4'b1111, 1'b0, 32'h0, 32'h0123_4567));
    drive_nop();
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_dbus.md
Name: mem_dbus

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register; output feeds the MEM/WB register.
- Non-memory ops: EX results pass straight through (combinational).
- Load/store ops: runs a registered strobe/ack data-bus transaction with byte-lane steering and sign/zero extension.
- Holds the pipeline through `stallreq_o` until the access completes.

Parameters:
- `ADDR_W`, 32, data-bus address width.
- `DATA_W`, 32, data-bus data width; only 32 is supported.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high (`RstEnable`).
- `stall`  in  6  pipeline stall vector; bit 4 = MEM/WB hold.
- `wdata_i`  in  32  EX result.
- `wd_i`  in  5  destination register.
- `wreg_i`  in  1  register write enable.
- `hi_i`  in  32  HI value.
- `lo_i`  in  32  LO value.
- `whilo_i`  in  1  HI/LO write enable.
- `aluop_i`  in  8  ALU opcode.
- `mem_addr_i`  in  32  effective address.
- `reg2_i`  in  32  store data.
- `wdata_o`  out  32  result to MEM/WB.
- `wd_o`  out  5  destination register to MEM/WB.
- `wreg_o`  out  1  register write enable to MEM/WB.
- `hi_o`  out  32  HI to MEM/WB.
- `lo_o`  out  32  LO to MEM/WB.
- `whilo_o`  out  1  HI/LO write enable to MEM/WB.
- `dbus_addr_o`  out  `ADDR_W`  word-aligned bus address (low 2 bits = 0).
- `dbus_data_o`  out  32  store data, replicated per lane.
- `dbus_sel_o`  out  4  byte enables.
- `dbus_we_o`  out  1  1 = write.
- `dbus_stb_o`  out  1  request strobe.
- `dbus_data_i`  in  32  read data.
- `dbus_ack_i`  in  1  transfer complete.
- `stallreq_o`  out  1  stall request to the pipeline controller.

Behaviour:
- Memory ops:
  - Loads: `EXE_LB_OP` 8'b11100000, `EXE_LBU_OP` 11100100, `EXE_LH_OP` 11100001, `EXE_LHU_OP` 11100101, `EXE_LW_OP` 11100011.
  - Stores: `EXE_SB_OP` 11101000, `EXE_SH_OP` 11101001, `EXE_SW_OP` 11101011.
  - Every other opcode is a non-memory op.
- Reset values: state IDLE; `dbus_stb_o`/`dbus_we_o` 0; `dbus_addr_o`/`dbus_data_o`/`dbus_sel_o`/`rdata_q` 0. Combinational outputs follow their inputs.
- Reset mid-transaction: the strobe drops on the reset edge. An `ack` that arrives while in IDLE is ignored.
- Byte lanes (big-endian):
  - Byte ops: `addr[1:0]` 00→sel 1000, data[31:24]; 01→0100; 10→0010; 11→0001.
  - Halfword ops: `addr[1]`=0→1100, data[31:16]; 1→0011, data[15:0].
  - Word ops: 1111.
- Store data is replicated: SB {4{b}}, SH {2{h}}, SW word.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Memory op present: `stallreq_o`=1. On the next edge, register addr/sel/we/data, assert `dbus_stb_o`, go BUSY.
  - Otherwise: `stallreq_o`=0 and outputs pass through.
- BUSY:
  - `stb` held and `stallreq_o`=1; bus outputs stable until ack.
  - On an edge with `ack`=1: capture `dbus_data_i` into `rdata_q`, drop `stb`, go DONE.
- DONE:
  - `stallreq_o`=0 and `stb`=0.
  - Loads: `wdata_o` = lane-extracted `rdata_q`. LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
  - If `stall[4]`=0: return to IDLE on that edge (the instruction retires into MEM/WB).
  - If `stall[4]`=1 (another stall source): stay in DONE and hold the result. No re-issue on the bus.
- Minimum occupancy for a memory op: 3 cycles (ack in the first BUSY cycle). Each extra wait cycle adds 1.
- Pass-through fields:
  - `wd_o`, `wreg_o`, `hi_o`, `lo_o`, `whilo_o` always equal their inputs.
  - `wdata_o` equals `wdata_i` except for loads in DONE.
  - Stores: `wdata_o` = `wdata_i`, `wreg_o` = `wreg_i`.
- A new memory op arriving in IDLE right after DONE starts a fresh transaction. Back-to-back ops never overlap.

Optional Feature:
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0, issue no bus cycle.
  - FSM goes IDLE→DONE in one cycle.
  - Loads: `wdata_o`=0 and `wreg_o`=0.
  - Stores write nothing.
  - `stallreq_o`=1 for the IDLE cycle only.
- Undefined: offending low address bits are ignored per the lane rules above; the access always proceeds.

Test Plan:
- Non-memory op (ADD result 0x12345678, `wd`=3, `wreg`=1) → outputs pass through with zero latency; `stallreq_o`=0; `stb` never asserted.
- LB at 0x1001, bus returns 0xAA80CCDD, ack in the first BUSY cycle:
  - `sel`=0100, `addr`=0x1000.
  - `stallreq_o` high for 2 cycles.
  - `wdata_o`=0xFFFFFF80.
  - Same transfer with LBU → `wdata_o`=0x00000080.
- SH at 0x2002 with `reg2`=0x0000BEEF → `sel`=0011, `we`=1, `data`=0xBEEFBEEF; `stb` held through 3 wait cycles until ack, then drops.
- LW completes (data 0xCAFEF00D) while `stall[4]`=1 for 4 cycles → FSM stays DONE, `wdata_o` stable at 0xCAFEF00D, exactly one `stb` transaction.
- `rst` asserted while in BUSY → next cycle `stb`=0, state IDLE; a late `ack` causes no capture.
- `MEM_ALIGN_CHECK_EN` defined, LW at 0x3001 → no `stb`, `wreg_o`=0, `stallreq_o` high for 1 cycle.
